// File: rtl/core_pkg.sv
// Shared core definitions: write-back source encodings, halt FSM states and
// default datapath/register-address widths used across the pipeline stages.
package core_pkg;

    localparam int unsigned CORE_DATA_W = 32;
    localparam int unsigned CORE_REG_AW = 3;

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_LINK = 2'b10;
    localparam logic [1:0] WB_SRC_RSVD = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_t;

endpackage

// File: rtl/mem_wb_stage_wb_mux.sv
// Combinational 4:1 write-back select; the reserved encoding falls back to
// the ALU result.
module wb_mux
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = CORE_DATA_W
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] mem,
    input  logic [DATA_W-1:0] link,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = alu;
        case (sel)
            WB_SRC_MEM:  data = mem;
            WB_SRC_LINK: data = link;
            default:     data = alu;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back select, halt tracking.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int unsigned DATA_W  = CORE_DATA_W,
    parameter int unsigned REG_AW  = CORE_REG_AW,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              MEM_Valid,
    input  logic              MEM_RegWrite,
    input  logic [1:0]        MEM_WB_Src,
    input  logic              MEM_Halt,
    input  logic [REG_AW-1:0] MEM_Rd,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] MEM_Data,
    input  logic [DATA_W-1:0] PC_plus1,
    output logic              WB_RegWrite,
    output logic [REG_AW-1:0] WB_Rd,
    output logic [DATA_W-1:0] WB_Data,
    output logic              FWD_Valid,
    output logic [REG_AW-1:0] FWD_Rd,
    output logic [DATA_W-1:0] FWD_Data,
    output logic              Halted
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       Retired
`endif
);

    logic              r_valid;
    logic              r_regwrite;
    logic [1:0]        r_wb_src;
    logic              r_halt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mem;
    logic [DATA_W-1:0] r_link;

    halt_state_t state, state_next;
    logic        halt_take;

    always_comb begin
        state_next = state;
        halt_take  = 1'b0;
        if (state == RUN && r_valid && r_halt && !Stall && !Flush) begin
            halt_take  = 1'b1;
            state_next = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // On the halting edge only valid drops, so the HALT's write is not repeated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || Flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_wb_src   <= '0;
            r_halt     <= 1'b0;
            r_rd       <= '0;
            r_alu      <= '0;
            r_mem      <= '0;
            r_link     <= '0;
        end else if (state == HALTED || Stall) begin
            r_valid    <= r_valid;
        end else if (halt_take) begin
            r_valid    <= 1'b0;
        end else begin
            r_valid    <= MEM_Valid;
            r_regwrite <= MEM_RegWrite;
            r_wb_src   <= MEM_WB_Src;
            r_halt     <= MEM_Halt;
            r_rd       <= MEM_Rd;
            r_alu      <= ALU_result;
            r_mem      <= MEM_Data;
            r_link     <= PC_plus1;
        end
    end

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .sel  (r_wb_src),
        .alu  (r_alu),
        .mem  (r_mem),
        .link (r_link),
        .data (WB_Data)
    );

    assign WB_RegWrite = r_valid & r_regwrite & ~(R0_ZERO & (r_rd == '0));
    assign WB_Rd       = r_rd;
    assign FWD_Valid   = WB_RegWrite;
    assign FWD_Rd      = WB_Rd;
    assign FWD_Data    = WB_Data;
    assign Halted      = (state == HALTED);

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (r_valid && !Stall && state != HALTED)
            retire_cnt <= retire_cnt + 32'd1;
    end

    assign Retired = retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic against a slot-level model. Define WB_RETIRE_CNT_EN to cover Retired.
module tb_mem_wb_stage;
    import core_pkg::*;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Stall, Flush, MEM_Valid, MEM_RegWrite, MEM_Halt;
    logic [1:0]    MEM_WB_Src;
    logic [AW-1:0] MEM_Rd;
    logic [DW-1:0] ALU_result, MEM_Data, PC_plus1;
    logic          WB_RegWrite, FWD_Valid, Halted;
    logic [AW-1:0] WB_Rd, FWD_Rd;
    logic [DW-1:0] WB_Data, FWD_Data;
    logic [31:0]   Retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush),
        .MEM_Valid(MEM_Valid), .MEM_RegWrite(MEM_RegWrite), .MEM_WB_Src(MEM_WB_Src),
        .MEM_Halt(MEM_Halt), .MEM_Rd(MEM_Rd), .ALU_result(ALU_result),
        .MEM_Data(MEM_Data), .PC_plus1(PC_plus1),
        .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
        .FWD_Valid(FWD_Valid), .FWD_Rd(FWD_Rd), .FWD_Data(FWD_Data),
        .Halted(Halted)
`ifdef WB_RETIRE_CNT_EN
        , .Retired(Retired)
`endif
    );

`ifndef WB_RETIRE_CNT_EN
    assign Retired = '0;
`endif

    // Instruction currently sitting in write-back, as the model sees it.
    typedef struct {
        bit         valid;
        bit         rw;
        bit [1:0]   src;
        bit         halt;
        bit [AW-1:0] rd;
        bit [DW-1:0] alu, mem, link;
    } slot_t;

    slot_t       m_slot;
    bit          m_halted;
    bit [31:0]   m_retired;

    function automatic bit [DW-1:0] m_data();
        if (m_slot.src == 2'd1) return m_slot.mem;
        if (m_slot.src == 2'd2) return m_slot.link;
        return m_slot.alu;
    endfunction

    function automatic bit m_we();
        return m_slot.valid && m_slot.rw && (m_slot.rd != 0);
    endfunction

    task automatic model_clear();
        m_slot    = '{default: '0};
        m_halted  = 1'b0;
        m_retired = '0;
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit leaves;
        leaves = m_slot.valid && !Stall && !m_halted;
        if (leaves) m_retired = m_retired + 1;
        if (Flush) begin
            m_slot = '{default: '0};
        end else if (m_halted || Stall) begin
            // instruction stays put
        end else if (m_slot.valid && m_slot.halt) begin
            m_halted     = 1'b1;
            m_slot.valid = 1'b0;
        end else begin
            m_slot = '{MEM_Valid, MEM_RegWrite, MEM_WB_Src, MEM_Halt, MEM_Rd,
                       ALU_result, MEM_Data, PC_plus1};
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic h, input logic [AW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                         input logic [DW-1:0] link);
        MEM_Valid = v; MEM_RegWrite = rw; MEM_WB_Src = src; MEM_Halt = h;
        MEM_Rd = rd; ALU_result = alu; MEM_Data = mem; PC_plus1 = link;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        drive(0, 0, 2'd0, 0, '0, '0, '0, '0);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        drive(1, 1, 2'd1, 0, 3'd5, 32'h55, 32'h66, 32'h77);
        repeat (2) @(negedge clk);
        checks++;
        if ({WB_RegWrite, WB_Rd, WB_Data, FWD_Valid, FWD_Rd, FWD_Data, Halted, Retired} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b rd=%0d data=%h fv=%b frd=%0d fdata=%h halted=%b ret=%h exp all 0",
                     WB_RegWrite, WB_Rd, WB_Data, FWD_Valid, FWD_Rd, FWD_Data, Halted, Retired);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        logic [DW+AW:0] exp;
        do_reset();
        @(negedge clk);
        drive(1, 1, 2'd1, 0, 3'd3, 32'h10, 32'hDEADBEEF, 32'h0);
        @(posedge clk); #1;
        exp = {1'b1, 3'd3, 32'hDEADBEEF};
        checks++;
        if ({WB_RegWrite, WB_Rd, WB_Data} !== exp) begin
            errors++;
            $display("FAIL load_wb got %h exp %h", {WB_RegWrite, WB_Rd, WB_Data}, exp);
        end
        checks++;
        if ({FWD_Valid, FWD_Rd, FWD_Data} !== exp) begin
            errors++;
            $display("FAIL load_fwd got %h exp %h", {FWD_Valid, FWD_Rd, FWD_Data}, exp);
        end
    endtask

    task automatic test_link_r0();
        logic [DW+AW:0] exp;
        @(negedge clk);
        drive(1, 1, 2'd2, 0, 3'd7, 32'h99, 32'h88, 32'h25);
        @(posedge clk); #1;
        exp = {1'b1, 3'd7, 32'h25};
        checks++;
        if ({WB_RegWrite, WB_Rd, WB_Data} !== exp) begin
            errors++;
            $display("FAIL link_wb got %h exp %h", {WB_RegWrite, WB_Rd, WB_Data}, exp);
        end
        @(negedge clk);
        drive(1, 1, 2'd2, 0, 3'd0, 32'h99, 32'h88, 32'h25);
        @(posedge clk); #1;
        exp = {1'b0, 3'd0, 32'h25};
        checks++;
        if ({WB_RegWrite, WB_Rd, WB_Data} !== exp || FWD_Valid !== 1'b0) begin
            errors++;
            $display("FAIL r0_suppress got %h fv=%b exp %h fv=0",
                     {WB_RegWrite, WB_Rd, WB_Data}, FWD_Valid, exp);
        end
    endtask

    task automatic test_stall_flush();
        logic [DW+AW:0] exp;
        exp = {1'b1, 3'd2, 32'h1234};
        @(negedge clk);
        drive(1, 1, 2'd0, 0, 3'd2, 32'h1234, 32'h0, 32'h4);
        @(posedge clk); #1;
        checks++;
        if ({WB_RegWrite, WB_Rd, WB_Data} !== exp) begin
            errors++;
            $display("FAIL stall_capture got %h exp %h", {WB_RegWrite, WB_Rd, WB_Data}, exp);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            Stall = 1'b1;
            drive(1, 1, 2'(i), 0, 3'd5, $urandom, $urandom, $urandom);
            @(posedge clk); #1;
            checks++;
            if ({WB_RegWrite, WB_Rd, WB_Data} !== exp) begin
                errors++;
                $display("FAIL stall_hold[%0d] got %h exp %h", i, {WB_RegWrite, WB_Rd, WB_Data}, exp);
            end
        end
        @(negedge clk);
        Flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (WB_RegWrite !== 1'b0 || FWD_Valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_stall got we=%b fv=%b exp 0 0", WB_RegWrite, FWD_Valid);
        end
        @(negedge clk);
        Flush = 1'b0; Stall = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        @(negedge clk);
        drive(1, 1, 2'd0, 0, 3'd1, 32'h11, 32'h0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if ({WB_RegWrite, WB_Rd, WB_Data, Halted} !== {1'b1, 3'd1, 32'h11, 1'b0}) begin
            errors++;
            $display("FAIL halt_add1 got we=%b rd=%0d data=%h halted=%b exp 1 1 11 0",
                     WB_RegWrite, WB_Rd, WB_Data, Halted);
        end
        @(negedge clk);
        drive(1, 1, 2'd0, 1, 3'd2, 32'h22, 32'h0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if ({WB_RegWrite, WB_Rd, WB_Data, Halted} !== {1'b1, 3'd2, 32'h22, 1'b0}) begin
            errors++;
            $display("FAIL halt_write got we=%b rd=%0d data=%h halted=%b exp 1 2 22 0",
                     WB_RegWrite, WB_Rd, WB_Data, Halted);
        end
        @(negedge clk);
        drive(1, 1, 2'd0, 0, 3'd3, 32'h33, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (Halted !== 1'b1 || WB_RegWrite !== 1'b0) begin
                errors++;
                $display("FAIL halt_sticky[%0d] got halted=%b we=%b exp 1 0", i, Halted, WB_RegWrite);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (Halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset got %b exp 0", Halted);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        drive(1, 1, 2'd0, 0, 3'd4, 32'hCAFE, 32'h0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (WB_RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got we=%b exp 1", WB_RegWrite);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({WB_RegWrite, WB_Rd, WB_Data, FWD_Valid, FWD_Rd, FWD_Data, Halted} !== '0) begin
            errors++;
            $display("FAIL async_clear got we=%b rd=%0d data=%h fv=%b exp all 0",
                     WB_RegWrite, WB_Rd, WB_Data, FWD_Valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire();
        int n;
        do_reset();
        n = 1;
        // 10 instructions, two stall edges, one flush bubble, then drain
        for (int e = 1; e <= 15; e++) begin
            @(negedge clk);
            Stall = (e == 3 || e == 4);
            Flush = (e == 6);
            if (e == 6 || e >= 14)
                drive(0, 0, 2'd0, 0, '0, '0, '0, '0);
            else begin
                drive(1, 1, 2'd0, 0, 3'd1, 32'(n), '0, '0);
                if (!Stall) n++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (Retired !== 32'd10) begin
            errors++;
            $display("FAIL retire_count got %0d exp 10", Retired);
        end
        @(negedge clk);
        Stall = 1'b0; Flush = 1'b0;
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt;
        drive(1, 1, 2'd0, 0, 3'd6, 32'h1, '0, '0);
        @(posedge clk); #1;
        checks++;
        if (Retired !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL retire_preload got %h exp ffffffff", Retired);
        end
        @(negedge clk);
        drive(0, 0, 2'd0, 0, '0, '0, '0, '0);
        @(posedge clk); #1;
        checks++;
        if (Retired !== 32'h0) begin
            errors++;
            $display("FAIL retire_wrap got %h exp 0", Retired);
        end
    endtask
`endif

    task automatic test_random();
        logic [DW+AW:0] exp;
        do_reset();
        model_clear();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_halted && ($urandom % 4 == 0)) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
                model_clear();
            end
            Stall = ($urandom % 5 == 0);
            Flush = ($urandom % 8 == 0);
            drive($urandom % 4 != 0, $urandom % 4 != 0, 2'($urandom), $urandom % 16 == 0,
                  AW'($urandom), $urandom, $urandom, $urandom);
            @(posedge clk);
            model_edge();
            #1;
            exp = {m_we(), m_slot.rd, m_data()};
            checks++;
            if ({WB_RegWrite, WB_Rd, WB_Data} !== exp || {FWD_Valid, FWD_Rd, FWD_Data} !== exp) begin
                errors++;
                $display("FAIL rand_wb[%0d] got %h fwd %h exp %h", i,
                         {WB_RegWrite, WB_Rd, WB_Data}, {FWD_Valid, FWD_Rd, FWD_Data}, exp);
            end
            checks++;
            if (Halted !== m_halted) begin
                errors++;
                $display("FAIL rand_halted[%0d] got %b exp %b", i, Halted, m_halted);
            end
`ifdef WB_RETIRE_CNT_EN
            checks++;
            if (Retired !== m_retired) begin
                errors++;
                $display("FAIL rand_retired[%0d] got %0d exp %0d", i, Retired, m_retired);
            end
`endif
        end
        @(negedge clk);
        Stall = 1'b0; Flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_link_r0();
        test_stall_flush();
        test_halt();
        test_async_reset();
`ifdef WB_RETIRE_CNT_EN
        test_retire();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register plus write-back stage of the 5-stage RISC core. Latches the memory stage's load data, ALU result, link address and control, then selects the write-back value. Drives the register-file write port and the forwarding bus to EX. Tracks processor halt, and optionally counts retired instructions.

Parameters:
DATA_W, 32, datapath width
REG_AW, 3, register address width (8 GPRs)
R0_ZERO, 1, 1 = writes to register 0 suppressed (hardwired zero)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
Stall  input  1  hazard unit: hold the MEM/WB register contents
Flush  input  1  hazard unit: insert a bubble into the MEM/WB register
MEM_Valid  input  1  memory-stage slot holds a real instruction
MEM_RegWrite  input  1  instruction writes a register
MEM_WB_Src  input  2  write-back source: 00 ALU, 01 memory, 10 link (PC+1), 11 reserved (selects ALU)
MEM_Halt  input  1  instruction is HALT
MEM_Rd  input  REG_AW  destination register
ALU_result  input  DATA_W  ALU result / effective address
MEM_Data  input  DATA_W  load data from the memory stage (0 when no read)
PC_plus1  input  DATA_W  link address
WB_RegWrite  output  1  register-file write enable
WB_Rd  output  REG_AW  register-file write address
WB_Data  output  DATA_W  register-file write data
FWD_Valid  output  1  forwarding bus valid (equals WB_RegWrite)
FWD_Rd  output  REG_AW  forwarding destination (equals WB_Rd)
FWD_Data  output  DATA_W  forwarding data (equals WB_Data)
Halted  output  1  sticky; HALT has retired
Retired  output  32  retired-instruction count (WB_RETIRE_CNT_EN only)

Behaviour:
- Pipeline register fields: valid, regwrite, wb_src, halt, rd, alu, mem, link.
- Register update priority, evaluated at each rising clk edge:
  1. rst_n low: asynchronous clear of every field.
  2. Flush: valid <= 0. Data fields are don't-care but are cleared.
  3. Halted = 1: hold all fields; no further capture.
  4. Stall: hold all fields.
  5. Otherwise: capture all MEM_* inputs.
- Latency: exactly 1 cycle from a MEM-side capture to WB_* outputs. WB_* outputs are combinational from the register only, with no path from the input ports.
- WB_Data by wb_src: 00 alu, 01 mem, 10 link, 11 alu.
- WB_RegWrite = valid & regwrite & ~(R0_ZERO & rd==0). WB_Rd = rd.
- When the write is suppressed, WB_Data is still driven; the register file ignores it.
- During Stall the held instruction keeps WB_RegWrite asserted every cycle. Rewriting the same register with the same value is idempotent.
- Halt FSM, states RUN and HALTED:
  - Reset state is RUN.
  - RUN -> HALTED on the edge after a register holding valid & halt, provided Stall = 0 and Flush = 0 on that edge.
  - HALTED is left only by reset.
  - Halted = (state == HALTED). Once HALTED, valid is forced to 0 on the same edge, so no duplicate writes occur.
- A HALT instruction with regwrite = 1 still performs its write in its WB cycle.
- Reset values: WB_RegWrite 0, WB_Rd 0, WB_Data 0, FWD_* 0, Halted 0, Retired 0.
- Reset asserted mid-stall or mid-halt clears everything immediately, asynchronously.
- Flush and Stall asserted together: Flush wins.

Optional Feature:
WB_RETIRE_CNT_EN.
- Defined: 32-bit Retired counter increments on every edge where the register holds valid = 1 and the instruction leaves WB. Leaving WB means Stall = 0, or Flush = 1 while valid and not stalled-out.
  - Simplified rule: increment when valid & ~Stall & ~Halted.
  - Wraps 0xFFFFFFFF -> 0.
  - A HALT instruction counts once.
- Undefined: Retired port is absent, and there is no counter logic.

Decomposition:
- Package core_pkg holds the WB_SRC_ALU/MEM/LINK/RSVD 2-bit constants, the halt_state_t enum {RUN, HALTED}, and the shared DATA_W/REG_AW defaults used by every stage.
- One sub-module, wb_mux: purely combinational 4:1 write-back select. Instantiated once; the pipeline register and FSM stay in the top module.

Test Plan:
- Load: MEM_Valid = 1, RegWrite = 1, WB_Src = 01, Rd = 3, MEM_Data = 0xDEADBEEF, ALU_result = 0x10. Next cycle: WB_RegWrite = 1, WB_Rd = 3, WB_Data = 0xDEADBEEF, FWD_* identical.
- Link and zero register:
  - WB_Src = 10, PC_plus1 = 0x25, Rd = 7 -> WB_Data = 0x25, write enabled.
  - Same with Rd = 0 -> WB_RegWrite = 0, FWD_Valid = 0.
- Stall/flush: ALU op 0x1234 -> Rd 2, then Stall = 1 for 3 cycles with different inputs -> outputs held at 0x1234/Rd 2. Then Flush = 1 with Stall = 1 -> next cycle WB_RegWrite = 0.
- Halt: ADD, HALT, ADD streamed -> Halted rises the cycle after HALT is in WB; the trailing ADD never asserts WB_RegWrite. Holding MEM_Valid = 1 afterwards -> stays halted. rst_n pulse -> Halted = 0.
- Async reset: assert rst_n = 0 mid-cycle while WB_RegWrite = 1 -> all outputs 0 before the next clk edge.
- WB_RETIRE_CNT_EN: 10 valid instructions with 2 stall cycles and 1 flush bubble -> Retired = 10. Preload the counter to 0xFFFFFFFF via force and retire 1 instruction -> Retired = 0.
